// File: rtl/layer_sequencer.sv
// layer_sequencer: runs the layer engines one at a time, acknowledges each finish,
// counts output samples per layer and guards each layer with a watchdog.
module layer_sequencer #(
    parameter int unsigned NUM_LAYERS     = 4,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned DRAIN_MAX      = 8,
    localparam int unsigned CL_W          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_finish,
    input  logic [NUM_LAYERS-1:0] layer_sample,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [NUM_LAYERS-1:0] ram_feedback,
    output logic [CL_W-1:0]       cur_layer,
    output logic [CNT_W-1:0]      sample_count,
    output logic [CNT_W-1:0]      last_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WD_MAX = (TIMEOUT_CYCLES > DRAIN_MAX) ? TIMEOUT_CYCLES : DRAIN_MAX;
    localparam int unsigned WD_W   = $clog2(WD_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIN,
        S_ACK,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t                  state, state_d;
    logic [WD_W-1:0]         watchdog, watchdog_d;
    logic [NUM_LAYERS-1:0]   layer_en_d, ram_feedback_d;
    logic [CL_W-1:0]         cur_layer_d;
    logic [CNT_W-1:0]        sample_count_d, last_count_d, sample_inc;
    logic                    busy_d, done_d, error_d;
    logic                    cur_fin, cur_smp, is_last;

    function automatic logic [NUM_LAYERS-1:0] onehot(input logic [CL_W-1:0] idx);
        onehot = NUM_LAYERS'(1) << idx;
    endfunction

    // Only the active layer's finish/sample bits matter; foreign bits are masked off
    assign cur_fin    = |(layer_finish & onehot(cur_layer));
    assign cur_smp    = |(layer_sample & onehot(cur_layer));
    assign is_last    = (cur_layer == CL_W'(NUM_LAYERS - 1));
    assign sample_inc = (&sample_count) ? sample_count : sample_count + CNT_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output logic; abort overrides every transition
    always_comb begin
        state_d        = state;
        layer_en_d     = '0;
        ram_feedback_d = '0;
        cur_layer_d    = cur_layer;
        sample_count_d = sample_count;
        last_count_d   = last_count;
        done_d         = 1'b0;
        error_d        = error;
        watchdog_d     = watchdog;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_WAIT_FIN;
                    cur_layer_d    = '0;
                    sample_count_d = '0;
                    watchdog_d     = '0;
                    layer_en_d     = onehot('0);
                end
            end
            S_WAIT_FIN: begin
                layer_en_d = onehot(cur_layer);
                watchdog_d = watchdog + WD_W'(1);
                if (cur_smp) begin
                    sample_count_d = sample_inc;
                end
                if (cur_fin) begin
                    state_d        = S_ACK;
                    layer_en_d     = '0;
                    ram_feedback_d = onehot(cur_layer);
                    last_count_d   = cur_smp ? sample_inc : sample_count;
                end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_ERR;
                    layer_en_d = '0;
                    error_d    = 1'b1;
                end
            end
            S_ACK: begin
                state_d    = S_DRAIN;
                watchdog_d = '0;
            end
            S_DRAIN: begin
                if (!cur_fin) begin
                    if (is_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = S_WAIT_FIN;
                        cur_layer_d    = cur_layer + CL_W'(1);
                        sample_count_d = '0;
                        watchdog_d     = '0;
                        layer_en_d     = onehot(cur_layer + CL_W'(1));
                    end
                end else if (watchdog == WD_W'(DRAIN_MAX - 1)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    watchdog_d = watchdog + WD_W'(1);
                end
            end
            S_ERR: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d        = S_IDLE;
            layer_en_d     = '0;
            ram_feedback_d = '0;
            cur_layer_d    = '0;
            sample_count_d = '0;
            watchdog_d     = '0;
            error_d        = 1'b0;
            done_d         = 1'b0;
        end

        busy_d = (state_d == S_WAIT_FIN) || (state_d == S_ACK) || (state_d == S_DRAIN);
    end

    // Registered outputs and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_en     <= '0;
            ram_feedback <= '0;
            cur_layer    <= '0;
            sample_count <= '0;
            last_count   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            watchdog     <= '0;
        end else begin
            layer_en     <= layer_en_d;
            ram_feedback <= ram_feedback_d;
            cur_layer    <= cur_layer_d;
            sample_count <= sample_count_d;
            last_count   <= last_count_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            watchdog     <= watchdog_d;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: per-cycle vector table plus multi-cycle sequences.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [3:0]  layer_finish, layer_sample;

    logic [3:0]  layer_en, ram_feedback;
    logic [1:0]  cur_layer;
    logic [15:0] sample_count, last_count;
    logic        busy, done, error;

    logic [3:0]  en4, rfb4;
    logic [1:0]  cur4;
    logic [3:0]  sc4, last4;
    logic        busy4, done4, err4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_LAYERS(4), .CNT_W(16), .TIMEOUT_CYCLES(100), .DRAIN_MAX(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_finish(layer_finish), .layer_sample(layer_sample),
        .layer_en(layer_en), .ram_feedback(ram_feedback), .cur_layer(cur_layer),
        .sample_count(sample_count), .last_count(last_count),
        .busy(busy), .done(done), .error(error)
    );

    layer_sequencer #(.NUM_LAYERS(4), .CNT_W(4), .TIMEOUT_CYCLES(100), .DRAIN_MAX(8)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_finish(layer_finish), .layer_sample(layer_sample),
        .layer_en(en4), .ram_feedback(rfb4), .cur_layer(cur4),
        .sample_count(sc4), .last_count(last4),
        .busy(busy4), .done(done4), .error(err4)
    );

    typedef struct {
        logic        st;
        logic        ab;
        logic [3:0]  fin;
        logic [3:0]  smp;
        logic [3:0]  en;
        logic [3:0]  rfb;
        logic [1:0]  cur;
        logic [15:0] sc;
        logic [15:0] last;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic st, input logic ab, input logic [3:0] fin,
                                input logic [3:0] smp, input logic [3:0] en, input logic [3:0] rfb,
                                input logic [1:0] cur, input logic [15:0] sc, input logic [15:0] last,
                                input logic bz, input logic dn, input logic er);
        vec_t v;
        v.st = st; v.ab = ab; v.fin = fin; v.smp = smp; v.en = en; v.rfb = rfb;
        v.cur = cur; v.sc = sc; v.last = last; v.busy = bz; v.done = dn; v.err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        start = 1'b0; layer_finish = '0; layer_sample = '0;
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    // Advance the current layer through ACK and DRAIN with a prompt finish
    task automatic pass_layer(input int l);
        layer_finish = 4'b0001 << l;
        step();
        layer_finish = '0;
        step();
        step();
    endtask

    function automatic logic [3:0] oh(input int l);
        logic [3:0] one;
        one = 4'b0001;
        return one << l;
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        layer_finish = '0; layer_sample = '0;

        // Reset state
        #2;
        chk("reset_outputs", {layer_en, ram_feedback, cur_layer, sample_count, last_count, busy, done, error}, 64'd0);
        chk("reset_cnt4", {sc4, last4, err4}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Per-cycle table: start, foreign bits, sample+finish same cycle, layer walk
        //                 st ab fin      smp      en       rfb      cur sc  last bz dn er
        vt.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 1,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b1000, 4'b0010, 4'b0001, 4'b0000, 0, 1,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 2,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 3,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 4,  4,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 4,  4,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0,  4,  1, 0, 0));
        vt.push_back(mk(1, 0, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 1, 1,  4,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1,  1,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1,  1,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 2, 0,  1,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2, 0,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 0,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3, 0,  0,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 3, 1,  1,  1, 0, 0));
        vt.push_back(mk(0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 3, 1,  1,  1, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            start = vt[i].st; abort = vt[i].ab;
            layer_finish = vt[i].fin; layer_sample = vt[i].smp;
            step();
            chk($sformatf("vec%0d", i),
                {layer_en, ram_feedback, cur_layer, sample_count, last_count, busy, done, error},
                {vt[i].en, vt[i].rfb, vt[i].cur, vt[i].sc, vt[i].last, vt[i].busy, vt[i].done, vt[i].err});
        end
        to_idle();

        // Normal run: 5 samples per layer, finish 10 cycles after the last sample
        start = 1'b1; step(); start = 1'b0;
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("run_en_L%0d", l), layer_en, oh(l));
            chk($sformatf("run_cur_L%0d", l), cur_layer, l);
            for (int k = 0; k < 5; k++) begin
                layer_sample = oh(l); step();
            end
            layer_sample = '0;
            chk($sformatf("run_sc_L%0d", l), sample_count, 5);
            for (int k = 0; k < 9; k++) step();
            chk($sformatf("run_hold_en_L%0d", l), {layer_en, ram_feedback}, {oh(l), 4'b0000});
            layer_finish = oh(l); step();
            chk($sformatf("run_ack_L%0d", l), {layer_en, ram_feedback, last_count}, {4'b0000, oh(l), 16'd5});
            step();
            chk($sformatf("run_rfb_drop_L%0d", l), ram_feedback, 4'b0000);
            layer_finish = '0; step();
            if (l < 3) begin
                chk($sformatf("run_next_L%0d", l), {layer_en, sample_count, done}, {oh(l + 1), 16'd0, 1'b0});
            end else begin
                chk("run_done", {layer_en, done, busy}, {4'b0000, 1'b1, 1'b0});
            end
        end
        step();
        chk("run_done_pulse", {done, busy}, 2'b00);

        // Watchdog: layer 1 never finishes
        start = 1'b1; step(); start = 1'b0;
        pass_layer(0);
        chk("wd_enter_L1", {layer_en, busy}, {4'b0010, 1'b1});
        for (int k = 0; k < 99; k++) step();
        chk("wd_before_expiry", {layer_en, busy, error}, {4'b0010, 1'b1, 1'b0});
        step();
        chk("wd_err", {layer_en, busy, error}, {4'b0000, 1'b0, 1'b1});
        start = 1'b1; step(); start = 1'b0;
        chk("wd_start_ignored", {layer_en, busy, error}, {4'b0000, 1'b0, 1'b1});
        abort = 1'b1; step(); abort = 1'b0;
        chk("wd_abort_clear", {layer_en, busy, error, cur_layer}, {4'b0000, 1'b0, 1'b0, 2'd0});

        // Drain timeout: layer 0 keeps finish high after its acknowledge
        start = 1'b1; step(); start = 1'b0;
        layer_finish = 4'b0001; step();
        chk("drain_ack", ram_feedback, 4'b0001);
        step();
        for (int k = 0; k < 7; k++) step();
        chk("drain_still", {busy, error}, 2'b10);
        step();
        chk("drain_err", {busy, error, cur_layer, layer_en}, {1'b0, 1'b1, 2'd0, 4'b0000});
        to_idle();

        // Abort mid-layer 2 with a finish in the same cycle
        start = 1'b1; step(); start = 1'b0;
        pass_layer(0);
        pass_layer(1);
        for (int k = 0; k < 3; k++) begin
            layer_sample = 4'b0100; step();
        end
        layer_sample = '0;
        chk("abort_pre", {cur_layer, sample_count}, {2'd2, 16'd3});
        abort = 1'b1; layer_finish = 4'b0100; step();
        chk("abort_edge", {layer_en, ram_feedback, cur_layer, sample_count, busy}, {4'b0000, 4'b0000, 2'd0, 16'd0, 1'b0});
        abort = 1'b0; layer_finish = '0; step();
        chk("abort_no_rfb", {ram_feedback, busy}, {4'b0000, 1'b0});
        start = 1'b1; step(); start = 1'b0;
        chk("abort_restart", {layer_en, cur_layer}, {4'b0001, 2'd0});
        to_idle();

        // Finish on the watchdog expiry cycle wins
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 99; k++) step();
        layer_finish = 4'b0001; step();
        chk("wd_finish_tie", {ram_feedback, error, busy}, {4'b0001, 1'b0, 1'b1});
        to_idle();

        // Saturation on the 4-bit counter instance
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            layer_sample = 4'b0001; step();
        end
        chk("sat_sc4", sc4, 4'd15);
        chk("sat_sc16", sample_count, 16'd20);
        layer_finish = 4'b0001; step();
        layer_sample = '0;
        chk("sat_last4", last4, 4'd15);
        chk("sat_last16", last_count, 16'd21);
        to_idle();

        // Asynchronous reset in the middle of ACK
        start = 1'b1; step(); start = 1'b0;
        layer_finish = 4'b0001; step();
        chk("rst_pre_ack", ram_feedback, 4'b0001);
        #2 rst = 1'b0;
        #1;
        chk("rst_async", {layer_en, ram_feedback, cur_layer, sample_count, last_count, busy, done, error}, 64'd0);
        layer_finish = '0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("rst_restart", {layer_en, busy, cur_layer}, {4'b0001, 1'b1, 2'd0});
        to_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
